// File: rtl/fpu_pkg.sv
// Shared constants, FSM state type and operand classification for the FPU multiplier.
package fpu_pkg;

  localparam int unsigned SIGN_W = 1;
  localparam int unsigned EXP_W  = 8;
  localparam int unsigned FRAC_W = 23;
  localparam int unsigned MANT_W = 24;
  localparam int unsigned PROD_W = 48;

  localparam int EXP_BIAS = 127;
  localparam int EXP_MAX  = 255;

  localparam logic [SIGN_W+EXP_W+FRAC_W-1:0] CANON_NAN = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    StIdle,
    StMult,
    StNorm,
    StPack
  } state_e;

  typedef struct packed {
    logic zero;
    logic inf;
    logic nan;
  } op_class_t;

  // Denormals (exp == 0) are treated as zero.
  function automatic op_class_t classify(input logic [EXP_W+FRAC_W-1:0] f);
    op_class_t c;
    c.zero = (f[EXP_W+FRAC_W-1:FRAC_W] == '0);
    c.inf  = (f[EXP_W+FRAC_W-1:FRAC_W] == '1) && (f[FRAC_W-1:0] == '0);
    c.nan  = (f[EXP_W+FRAC_W-1:FRAC_W] == '1) && (f[FRAC_W-1:0] != '0);
    return c;
  endfunction

endpackage

// File: rtl/fpu_mant_mult_iter.sv
// 24x24 shift-add mantissa multiplier: one partial product per clock after load.
module fpu_mant_mult_iter
  import fpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [MANT_W-1:0] a,
  input  logic [MANT_W-1:0] b,
  output logic              busy,
  output logic              last,
  output logic [PROD_W-1:0] product
);

  logic [MANT_W-1:0] a_q, b_q;
  logic [PROD_W-1:0] acc_q;
  logic [4:0]        cnt_q;
  logic              run_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else if (load) begin
      a_q   <= a;
      b_q   <= b;
      acc_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b1;
    end else if (run_q) begin
      if (b_q[cnt_q]) begin
        acc_q <= acc_q + ({{MANT_W{1'b0}}, a_q} << cnt_q);
      end
      if (cnt_q == 5'(MANT_W - 1)) begin
        run_q <= 1'b0;
      end else begin
        cnt_q <= cnt_q + 5'd1;
      end
    end
  end

  assign busy    = run_q;
  // High during the final iteration so the controller can leave MULT on that edge.
  assign last    = run_q && (cnt_q == 5'(MANT_W - 1));
  assign product = acc_q;

endmodule

// File: rtl/fpu_multiplication_seq.sv
// Iterative single-precision multiplier, 26-cycle fixed latency start-to-done.
// Define ROUND_NEAREST_EN for round-to-nearest-even; otherwise the result is truncated.
module fpu_multiplication_seq
  import fpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] float_num1,
  input  logic [31:0] float_num2,
  output logic        busy,
  output logic        done,
  output logic [31:0] mul_result,
  output logic        overflow,
  output logic        underflow,
  output logic        invalid
);

  state_e state_q, state_d;

  logic              sign_q, nan_q, inf_q, zero_q;
  logic signed [9:0] exp_base_q, exp_q;
  logic [FRAC_W-1:0] frac_q;
  logic              round_q;

  op_class_t         cls1, cls2;
  logic              load;
  logic signed [9:0] exp_base_d;
  logic              iter_busy, iter_last;
  logic [PROD_W-1:0] product;

  assign cls1 = classify(float_num1[30:0]);
  assign cls2 = classify(float_num2[30:0]);
  assign load = (state_q == StIdle) && start;
  assign exp_base_d = $signed({2'b00, float_num1[30:23]}) + $signed({2'b00, float_num2[30:23]})
                      - 10'(EXP_BIAS);

  fpu_mant_mult_iter u_mant (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .a       ({1'b1, float_num1[FRAC_W-1:0]}),
    .b       ({1'b1, float_num2[FRAC_W-1:0]}),
    .busy    (iter_busy),
    .last    (iter_last),
    .product (product)
  );

  logic              unused_iter;
  assign unused_iter = iter_busy;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StMult;
      StMult:  if (iter_last) state_d = StNorm;
      StNorm:  state_d = StPack;
      StPack:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Normalisation: product of two 1.x mantissas lies in [1, 4).
  logic [FRAC_W-1:0] norm_frac;
  logic              norm_guard, norm_sticky, norm_round;
  logic signed [9:0] norm_exp;

  always_comb begin
    if (product[PROD_W-1]) begin
      norm_frac   = product[46:24];
      norm_guard  = product[23];
      norm_sticky = |product[22:0];
      norm_exp    = exp_base_q + 10'sd1;
    end else begin
      norm_frac   = product[45:23];
      norm_guard  = product[22];
      norm_sticky = |product[21:0];
      norm_exp    = exp_base_q;
    end
  end

`ifdef ROUND_NEAREST_EN
  assign norm_round = norm_guard & (norm_sticky | norm_frac[0]);
`else
  logic unused_round;
  assign unused_round = norm_guard ^ norm_sticky;
  assign norm_round   = 1'b0;
`endif

  logic [FRAC_W:0]   frac_sum;
  logic signed [9:0] exp_rnd;
  logic [31:0]       result_d;
  logic              ovf_d, unf_d, inv_d;

  always_comb begin
    frac_sum = {1'b0, frac_q} + {{FRAC_W{1'b0}}, round_q};
    exp_rnd  = exp_q + $signed({9'd0, frac_sum[FRAC_W]});
    result_d = {sign_q, exp_rnd[7:0], frac_sum[FRAC_W-1:0]};
    ovf_d    = 1'b0;
    unf_d    = 1'b0;
    inv_d    = 1'b0;
    if (nan_q) begin
      result_d = CANON_NAN;
      inv_d    = 1'b1;
    end else if (inf_q) begin
      result_d = {sign_q, 8'hFF, 23'h0};
    end else if (zero_q) begin
      result_d = {sign_q, 31'h0};
    end else if (exp_rnd >= $signed(10'(EXP_MAX))) begin
      result_d = {sign_q, 8'hFF, 23'h0};
      ovf_d    = 1'b1;
    end else if (exp_rnd <= 10'sd0) begin
      result_d = {sign_q, 31'h0};
      unf_d    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      busy       <= 1'b0;
      done       <= 1'b0;
      mul_result <= '0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
      invalid    <= 1'b0;
      sign_q     <= 1'b0;
      nan_q      <= 1'b0;
      inf_q      <= 1'b0;
      zero_q     <= 1'b0;
      exp_base_q <= '0;
      exp_q      <= '0;
      frac_q     <= '0;
      round_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      done    <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            busy       <= 1'b1;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
            invalid    <= 1'b0;
            sign_q     <= float_num1[31] ^ float_num2[31];
            nan_q      <= cls1.nan | cls2.nan | (cls1.inf & cls2.zero) | (cls2.inf & cls1.zero);
            inf_q      <= cls1.inf | cls2.inf;
            zero_q     <= cls1.zero | cls2.zero;
            exp_base_q <= exp_base_d;
          end
        end
        StNorm: begin
          frac_q  <= norm_frac;
          round_q <= norm_round;
          exp_q   <= norm_exp;
        end
        StPack: begin
          mul_result <= result_d;
          overflow   <= ovf_d;
          underflow  <= unf_d;
          invalid    <= inv_d;
          done       <= 1'b1;
          busy       <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
